// File: rtl/mux8_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter (mux8_arb_2).
package mux8_arb_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_S = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_S = 2'd2
    } arb_state_e;

    // True when the beat being transferred now is the last one the burst allows.
    function automatic logic burst_end(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W:0]   max_burst);
        return (({1'b0, cnt} + 5'd1) == max_burst);
    endfunction

endpackage

// File: rtl/mux8_arb_2_if.sv
// Handshake bundle for mux8_arb_2: two request ports, mux select and the output stage.
interface mux8_arb_2_if;
    import mux8_arb_pkg::*;

    logic              a_valid;
    logic [DATA_W-1:0] a;
    logic              a_ready;
    logic              s_valid;
    logic [DATA_W-1:0] s;
    logic              s_ready;
    logic              sel;
    logic              g_valid;
    logic [DATA_W-1:0] g;
    logic              g_ready;

    modport slave (
        input  a_valid, a, s_valid, s, g_ready,
        output a_ready, s_ready, sel, g_valid, g
    );

    modport master (
        output a_valid, a, s_valid, s, g_ready,
        input  a_ready, s_ready, sel, g_valid, g
    );

endinterface

// File: rtl/mux8_bit_2.sv
// 8-bit 2:1 datapath mux: sel=0 routes a, sel=1 routes s.
module mux8_bit_2
    import mux8_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] s,
    input  logic              sel,
    output logic [DATA_W-1:0] y
);

    // Pure select, no state.
    always_comb begin
        if (sel == SEL_S) begin
            y = s;
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/mux8_arb_2.sv
// Two-requester arbiter/sequencer owning the shared mux select, with a one-entry output stage.
// Optional build macro MUX8_ARB_FIXED_PRI_EN: A has strict priority and is never pre-empted.
module mux8_arb_2
    import mux8_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
)(
    input  logic           clk,
    input  logic           rst_n,
    mux8_arb_2_if.slave    bus
);

    localparam logic [CNT_W:0] MAX_BURST_C = (CNT_W+1)'(MAX_BURST);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              last_r;
    logic              last_nxt_s;
    logic              sel_r;
    logic [DATA_W-1:0] g_r;
    logic              g_valid_r;

    logic              accept_s;
    logic              a_ready_s;
    logic              s_ready_s;
    logic              a_xfer_s;
    logic              s_xfer_s;
    logic              xfer_s;
    logic [DATA_W-1:0] mux_s;

    mux8_bit_2 u_mux (
        .a   (bus.a),
        .s   (bus.s),
        .sel (sel_r),
        .y   (mux_s)
    );

    // State register with burst counter and last-granted tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            last_r  <= SEL_S;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Next-state, burst count and last-winner selection.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        last_nxt_s  = last_r;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = 4'd0;
                if (bus.a_valid && bus.s_valid) begin
`ifdef MUX8_ARB_FIXED_PRI_EN
                    state_nxt_s = GRANT_A;
`else
                    state_nxt_s = (last_r == SEL_S) ? GRANT_A : GRANT_S;
`endif
                end else if (bus.a_valid) begin
                    state_nxt_s = GRANT_A;
                end else if (bus.s_valid) begin
                    state_nxt_s = GRANT_S;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT_A: begin
                if (a_xfer_s) begin
`ifdef MUX8_ARB_FIXED_PRI_EN
                    // A keeps the grant until it stops presenting beats.
                    cnt_nxt_s = 4'd0;
`else
                    if (burst_end(cnt_r, MAX_BURST_C)) begin
                        cnt_nxt_s = 4'd0;
                        if (bus.s_valid) begin
                            state_nxt_s = GRANT_S;
                        end else begin
                            state_nxt_s = GRANT_A;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + 4'd1;
                    end
`endif
                end else if (!bus.a_valid) begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = bus.s_valid ? GRANT_S : IDLE;
                end else begin
                    state_nxt_s = GRANT_A;
                end
            end
            GRANT_S: begin
                if (s_xfer_s) begin
                    if (burst_end(cnt_r, MAX_BURST_C)) begin
                        cnt_nxt_s = 4'd0;
                        if (bus.a_valid) begin
                            state_nxt_s = GRANT_A;
                        end else begin
                            state_nxt_s = GRANT_S;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + 4'd1;
                    end
                end else if (!bus.s_valid) begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = bus.a_valid ? GRANT_A : IDLE;
                end else begin
                    state_nxt_s = GRANT_S;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase

        if (state_nxt_s == GRANT_A) begin
            last_nxt_s = SEL_A;
        end else if (state_nxt_s == GRANT_S) begin
            last_nxt_s = SEL_S;
        end else begin
            last_nxt_s = last_r;
        end
    end

    // Handshake outputs, decoded from registered state and output-stage occupancy.
    always_comb begin
        accept_s  = !g_valid_r || bus.g_ready;
        a_ready_s = (state_r == GRANT_A) && accept_s;
        s_ready_s = (state_r == GRANT_S) && accept_s;
        a_xfer_s  = bus.a_valid && a_ready_s;
        s_xfer_s  = bus.s_valid && s_ready_s;
        xfer_s    = a_xfer_s || s_xfer_s;
    end

    // Mux select follows the grant being entered so the new owner is routed with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r <= SEL_A;
        end else if (state_nxt_s == GRANT_A) begin
            sel_r <= SEL_A;
        end else if (state_nxt_s == GRANT_S) begin
            sel_r <= SEL_S;
        end else begin
            sel_r <= sel_r;
        end
    end

    // Single-entry output stage; load and drain may happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_r       <= 8'd0;
            g_valid_r <= 1'b0;
        end else if (xfer_s) begin
            g_r       <= mux_s;
            g_valid_r <= 1'b1;
        end else if (bus.g_ready) begin
            g_r       <= g_r;
            g_valid_r <= 1'b0;
        end else begin
            g_r       <= g_r;
            g_valid_r <= g_valid_r;
        end
    end

    assign bus.a_ready = a_ready_s;
    assign bus.s_ready = s_ready_s;
    assign bus.sel     = sel_r;
    assign bus.g_valid = g_valid_r;
    assign bus.g       = g_r;

endmodule

// File: doc/mux8_arb_2.md
Name: mux8_arb_2

Overview:
- Two-requester arbiter and sequencer for the shared 8-bit 2:1 datapath mux; owns the mux select.
- Requester A (port a) and requester S (port s) each present 8-bit beats on a valid/ready handshake.
- The block grants one requester at a time, with bounded bursts and round-robin fairness, and drives the mux select.
- Selected data goes into a single-entry registered output stage with its own valid/ready handshake.

Parameters:
- MAX_BURST, 4: maximum beats per grant while the other requester is waiting; legal range 1..15.

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- a_valid  input  1  requester A has a beat
- a  input  8  requester A data
- a_ready  output  1  requester A beat accepted this cycle
- s_valid  input  1  requester S has a beat
- s  input  8  requester S data
- s_ready  output  1  requester S beat accepted this cycle
- sel  output  1  mux select; 0 routes a, 1 routes s
- g_valid  output  1  output register holds a beat
- g  output  8  output data
- g_ready  input  1  downstream accepts g this cycle

Behaviour:
- Reset (async assert, sync release): state=IDLE, burst cnt=0, last=S (so A wins first tie), sel=0, g=0, g_valid=0, a_ready=s_ready=0. An in-flight beat is dropped.
- accept = !g_valid || g_ready.
- a_ready = (state==GRANT_A) && accept. s_ready = (state==GRANT_S) && accept. Both are combinational from registered state.
- Beat transfer: x_valid && x_ready.
- On a transfer: g <= mux output and g_valid <= 1. Otherwise, if g_ready, then g_valid <= 0.
- Latency: valid rises in cycle N while IDLE → grant registered at N+1 → ready asserted at N+1 (if accept) → g_valid at N+2.
- States: IDLE, GRANT_A, GRANT_S.
- IDLE:
  - Both valid → grant the requester that is not last; cnt=0.
  - One valid → grant it; cnt=0.
  - None → stay.
- GRANT_X, X has a transfer:
  - cnt+1 == MAX_BURST and other valid → GRANT_other, cnt=0.
  - cnt+1 == MAX_BURST and other not valid → stay, cnt=0.
  - Otherwise → stay, cnt+1.
- GRANT_X, x_valid low:
  - Other valid → GRANT_other, cnt=0.
  - Else → IDLE.
- GRANT_X, x_valid high but stalled (accept=0): hold state and cnt; no forced switch.
- last <= X whenever GRANT_X is entered.
- sel = 1 in GRANT_S, 0 in GRANT_A; holds its previous value in IDLE.
- A requester must hold data stable while valid && !ready. Deasserting valid without a transfer ends the burst.
- A switch costs no bubble: the new grant's ready can assert in the cycle right after the switch decision.
- Simultaneous g_ready and transfer: the old beat leaves and the new beat loads in the same cycle (full throughput).

Optional Feature:
- Macro: MUX8_ARB_FIXED_PRI_EN.
- Defined:
  - A strictly beats S on IDLE ties; last is ignored.
  - MAX_BURST limit applies only to S. A is never pre-empted, and a burst from A runs until a_valid drops.
- Undefined: round-robin and burst limit as above.

Decomposition:
- Package mux8_arb_pkg: state enum (IDLE, GRANT_A, GRANT_S), DATA_W=8 constant, SEL_A=0 / SEL_S=1 constants.
- Sub-module: instantiate the existing mux8_bit_2 as the datapath (a, s, sel → mux out). The arbiter contains only FSM, counter and output register.

Test Plan:
- Single requester: a_valid=1 with a=0x11,0x22,0x33, g_ready=1, s idle → a_ready from cycle N+1; g shows 0x11,0x22,0x33 on consecutive cycles from N+2; sel=0.
- Tie after reset: both valid at once → GRANT_A first (last=S); with MAX_BURST=4, A gets 4 beats, then S gets 4, alternating; sel toggles accordingly.
- Backpressure: g_ready=0 for 5 cycles mid-burst of S → g holds value, s_ready=0, cnt frozen, no switch despite a_valid=1; resumes on g_ready=1.
- Early end: S sends 2 beats then drops s_valid while a_valid=1 → next cycle GRANT_A, cnt=0, sel=0.
- Reset mid-burst: assert rst_n=0 while g_valid=1 → g_valid, g, readies, sel go to 0 immediately, without waiting for a clock edge; after release, arbitration restarts in IDLE.
- MUX8_ARB_FIXED_PRI_EN build: both valid continuously → A served indefinitely, S never granted; drop a_valid → S granted next cycle.
